// File: rtl/pim_pkg.sv
// Shared definitions for the PIM MAC scheduler.
//   pim_state_e     : scheduler FSM state encoding
//   TIMEOUT_DEFAULT : default number of cycles allowed in WAIT before abort
package pim_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } pim_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/pim_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req upward starting at index ptr+1 (modulo NUM_REQ) and reports the first
// set bit as a one-hot grant plus its binary index. With req all zero, grant and
// index are zero.
//   req   : request vector
//   ptr   : index of the previous winner
//   grant : one-hot winner
//   index : binary index of the winner
module pim_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant    = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // i runs 1..NUM_REQ so the previous winner is checked last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                index           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/pim_mac_scheduler.sv
// Shares one MAC engine among NUM_REQ requesters.
// A round-robin winner is picked in IDLE, the engine is started with a one-cycle
// pulse, the result (or a timeout error) is held as a response until the owner
// accepts it, and completed transactions are counted.
//   clk, rst              : clock, synchronous active-high reset
//   req / grant           : level requests, one-hot owner held from START through RESP
//   rsp_valid / rsp_ready : response handshake
//   rsp_id / rsp_data / rsp_err : owner index, engine result, timeout flag
//   eng_start / eng_busy / eng_done / eng_result : engine interface
//   txn_count             : completed transactions, wrapping
module pim_mac_scheduler
    import pim_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned RESULT_W = 64,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  grant,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDX_W-1:0]    rsp_id,
    output logic [RESULT_W-1:0] rsp_data,
    output logic                rsp_err,
    output logic                eng_start,
    input  logic                eng_busy,
    input  logic                eng_done,
    input  logic [RESULT_W-1:0] eng_result,
    output logic [15:0]         txn_count
);

    localparam int unsigned TMR_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    pim_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr;
    logic [TMR_W-1:0] timer;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_index;
    logic               win;
    logic               timed_out;

    pim_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .index (arb_index)
    );

    assign win       = (state_q == StIdle) && (|req) && !eng_busy;
    assign timed_out = (timer == TMR_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (eng_done || timed_out) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        eng_start = (state_q == StStart);
        rsp_valid = (state_q == StResp);
    end

    // Transaction datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
            timer     <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win) begin
                        grant  <= arb_grant;
                        rsp_id <= arb_index;
                    end
                end
                StStart: begin
                    ptr   <= rsp_id;
                    timer <= '0;
                end
                StWait: begin
                    // A done arriving on the timeout cycle still delivers its result.
                    if (eng_done) begin
                        rsp_data <= eng_result;
                        rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        grant     <= '0;
                        txn_count <= txn_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_mac_scheduler.sv
module tb_pim_mac_scheduler;

    localparam int NR = 4;
    localparam int RW = 64;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] grant;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [RW-1:0] rsp_data;
    logic          rsp_err;
    logic          eng_start;
    logic          eng_busy = 1'b0;
    logic          eng_done;
    logic [RW-1:0] eng_result;
    logic [15:0]   txn_count;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: previous winner and completed transactions
    int m_last = NR - 1;
    int m_txn = 0;

    always #5 clk = ~clk;

    pim_mac_scheduler #(
        .NUM_REQ  (NR),
        .RESULT_W (RW),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_busy   (eng_busy),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .txn_count  (txn_count)
    );

    // Engine model: done pulses eng_lat+1 cycles after the start pulse unless hung.
    logic          model_done = 1'b0;
    logic          stray_done = 1'b0;
    logic [RW-1:0] eng_val = '0;
    int            eng_lat = 2;
    bit            eng_hang = 1'b0;
    int            e_cnt = 0;
    bit            e_pend = 1'b0;
    int            n_starts = 0;

    assign eng_done   = model_done | stray_done;
    assign eng_result = eng_val;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (eng_start) n_starts <= n_starts + 1;
        if (rst) begin
            e_pend <= 1'b0;
        end else if (eng_start) begin
            e_pend <= 1'b1;
            e_cnt  <= eng_lat;
        end else if (e_pend && !eng_hang) begin
            if (e_cnt == 0) begin
                model_done <= 1'b1;
                e_pend     <= 1'b0;
            end else begin
                e_cnt <= e_cnt - 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Round-robin rule: first set request searching upward from last+1.
    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        int c;
        for (int i = 1; i <= NR; i++) begin
            c = (last + i) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        rsp_ready = 1'b0;
        eng_busy  = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        m_last = NR - 1;
        m_txn  = 0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (eng_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({grant, rsp_valid, eng_start, rsp_err, rsp_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant=%b valid=%b start=%b err=%b id=%0d want all 0",
                     grant, rsp_valid, eng_start, rsp_err, rsp_id);
        end
        n_checks++;
        if (rsp_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", rsp_data);
        end
        n_checks++;
        if (txn_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_txn: got %0d want 0", txn_count);
        end
    endtask

    task automatic test_single();
        bit ok;
        int cyc, s0, exp;
        eng_hang = 1'b0;
        eng_lat  = 5;
        eng_val  = '0;
        for (int i = 0; i < 16; i++) eng_val += RW'((i + 1) * 2 * (i + 1));
        s0  = n_starts;
        req = 4'b0001;
        @(negedge clk);
        wait_start(ok);
        exp = rr_pick(4'b0001, m_last);
        m_last = exp;
        n_checks++;
        if (!ok || grant !== (4'b0001 << exp)) begin
            n_fail++; $display("FAIL single_grant: got %b (start seen %0b) want %b",
                               grant, ok, 4'b0001 << exp);
        end
        req = '0;  // owner drops req, transaction must still complete
        wait_valid(ok, cyc);
        n_checks++;
        if (!ok || rsp_data !== 64'd2992) begin
            n_fail++; $display("FAIL single_data: got %0d (valid %0b) want 2992", rsp_data, ok);
        end
        n_checks++;
        if (rsp_id !== 2'(exp) || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL single_id_err: got id=%0d err=%b want id=%0d err=0",
                               rsp_id, rsp_err, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_txn++;
        n_checks++;
        if (rsp_valid !== 1'b0 || grant !== '0 || txn_count !== 16'(m_txn)) begin
            n_fail++; $display("FAIL single_accept: got valid=%b grant=%b txn=%0d want 0 0 %0d",
                               rsp_valid, grant, txn_count, m_txn);
        end
        n_checks++;
        if (n_starts - s0 !== 1) begin
            n_fail++; $display("FAIL single_starts: got %0d want 1", n_starts - s0);
        end
    endtask

    task automatic test_contention();
        bit ok;
        int cyc, s0, sk, exp;
        do_reset();
        eng_lat   = 2;
        eng_val   = {$urandom, $urandom};
        req       = 4'b1111;
        rsp_ready = 1'b1;
        s0 = n_starts;
        for (int k = 0; k < 5; k++) begin
            sk = n_starts;
            wait_start(ok);
            if (k == 4) req = '0;
            exp = rr_pick(4'b1111, m_last);
            m_last = exp;
            n_checks++;
            if (!ok || grant !== (4'b0001 << exp)) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got %b want %b",
                                   k, grant, 4'b0001 << exp);
            end
            @(negedge clk);
            wait_valid(ok, cyc);
            n_checks++;
            if (!ok || rsp_data !== eng_val || n_starts - sk !== 1) begin
                n_fail++; $display("FAIL contention_rsp[%0d]: got data=%h starts=%0d want %h 1",
                                   k, rsp_data, n_starts - sk, eng_val);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        m_txn += 5;
        n_checks++;
        if (txn_count !== 16'(m_txn) || n_starts - s0 !== 5) begin
            n_fail++; $display("FAIL contention_totals: got txn=%0d starts=%0d want %0d 5",
                               txn_count, n_starts - s0, m_txn);
        end
    endtask

    task automatic test_random();
        bit ok;
        int cyc, s0, exp;
        logic [NR-1:0] r;
        eng_hang = 1'b0;
        for (int k = 0; k < 12; k++) begin
            r       = NR'($urandom_range(1, 15));
            eng_lat = $urandom_range(0, 10);
            eng_val = {$urandom, $urandom};
            s0      = n_starts;
            req     = r;
            @(negedge clk);
            wait_start(ok);
            exp = rr_pick(r, m_last);
            m_last = exp;
            n_checks++;
            if (!ok || grant !== (4'b0001 << exp)) begin
                n_fail++; $display("FAIL random_grant[%0d]: req=%b got %b want %b",
                                   k, r, grant, 4'b0001 << exp);
            end
            req = NR'($urandom_range(0, 15));  // not sampled outside IDLE
            wait_valid(ok, cyc);
            n_checks++;
            if (!ok || rsp_data !== eng_val || rsp_id !== 2'(exp) || rsp_err !== 1'b0) begin
                n_fail++; $display("FAIL random_rsp[%0d]: got data=%h id=%0d err=%b want %h %0d 0",
                                   k, rsp_data, rsp_id, rsp_err, eng_val, exp);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            req = '0;
            m_txn++;
            n_checks++;
            if (txn_count !== 16'(m_txn) || n_starts - s0 !== 1) begin
                n_fail++; $display("FAIL random_txn[%0d]: got txn=%0d starts=%0d want %0d 1",
                                   k, txn_count, n_starts - s0, m_txn);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc, exp;
        eng_hang = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        wait_start(ok);
        exp = rr_pick(4'b0100, m_last);
        m_last = exp;
        n_checks++;
        if (!ok || grant !== (4'b0001 << exp)) begin
            n_fail++; $display("FAIL timeout_grant: got %b want %b", grant, 4'b0001 << exp);
        end
        req = '0;
        wait_valid(ok, cyc);
        // cyc counts the START cycle plus TO cycles spent in WAIT
        n_checks++;
        if (!ok || cyc !== TO + 1) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d", cyc, TO + 1);
        end
        n_checks++;
        if (rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 2'(exp)) begin
            n_fail++; $display("FAIL timeout_rsp: got err=%b data=%h id=%0d want 1 0 %0d",
                               rsp_err, rsp_data, rsp_id, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        eng_hang  = 1'b0;
        m_txn++;
        n_checks++;
        if (txn_count !== 16'(m_txn)) begin
            n_fail++; $display("FAIL timeout_txn: got %0d want %0d", txn_count, m_txn);
        end
        repeat (12) @(negedge clk);  // let the stale engine pulse drain
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc, s0, exp;
        eng_lat = 3;
        eng_val = {$urandom, $urandom};
        req = 4'b1111;
        @(negedge clk);
        wait_start(ok);
        exp = rr_pick(4'b1111, m_last);
        m_last = exp;
        n_checks++;
        if (!ok || grant !== (4'b0001 << exp)) begin
            n_fail++; $display("FAIL bp_grant: got %b want %b", grant, 4'b0001 << exp);
        end
        wait_valid(ok, cyc);
        s0 = n_starts;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== eng_val || grant !== (4'b0001 << exp) ||
                eng_start !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h grant=%b start=%b",
                                   i, rsp_valid, rsp_data, grant, eng_start);
            end
            @(negedge clk);
        end
        n_checks++;
        if (n_starts !== s0 || txn_count !== 16'(m_txn)) begin
            n_fail++; $display("FAIL bp_idle: got starts+%0d txn=%0d want +0 %0d",
                               n_starts - s0, txn_count, m_txn);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req = '0;
        m_txn++;
        n_checks++;
        if (txn_count !== 16'(m_txn)) begin
            n_fail++; $display("FAIL bp_txn: got %0d want %0d", txn_count, m_txn);
        end
    endtask

    task automatic test_busy();
        bit ok;
        int cyc, exp;
        eng_lat  = 2;
        eng_busy = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== '0 || eng_start !== 1'b0) begin
                n_fail++; $display("FAIL busy_hold[%0d]: got grant=%b start=%b want 0 0",
                                   i, grant, eng_start);
            end
        end
        eng_busy = 1'b0;
        @(negedge clk);
        exp = rr_pick(4'b0010, m_last);
        m_last = exp;
        n_checks++;
        if (eng_start !== 1'b1 || grant !== (4'b0001 << exp)) begin
            n_fail++; $display("FAIL busy_release: got start=%b grant=%b want 1 %b",
                               eng_start, grant, 4'b0001 << exp);
        end
        req = '0;
        wait_valid(ok, cyc);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_txn++;
        n_checks++;
        if (!ok || txn_count !== 16'(m_txn)) begin
            n_fail++; $display("FAIL busy_txn: got %0d want %0d", txn_count, m_txn);
        end
    endtask

    task automatic test_reset_wait();
        bit ok;
        int cyc, exp;
        eng_hang = 1'b1;
        req = 4'b1000;
        @(negedge clk);
        wait_start(ok);
        req = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = NR - 1;
        m_txn  = 0;
        eng_hang = 1'b0;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({grant, rsp_valid, eng_start, rsp_err, rsp_id} !== '0 || rsp_data !== '0 ||
                txn_count !== 16'd0) begin
                n_fail++; $display("FAIL rstwait_quiet[%0d]: grant=%b valid=%b start=%b err=%b data=%h txn=%0d",
                                   i, grant, rsp_valid, eng_start, rsp_err, rsp_data, txn_count);
            end
            @(negedge clk);
        end
        eng_lat = 1;
        req = 4'b1111;
        @(negedge clk);
        wait_start(ok);
        exp = rr_pick(4'b1111, m_last);
        m_last = exp;
        n_checks++;
        if (!ok || grant !== (4'b0001 << exp)) begin
            n_fail++; $display("FAIL rstwait_grant: got %b want %b", grant, 4'b0001 << exp);
        end
        req = '0;
        wait_valid(ok, cyc);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_random();
        test_timeout();
        test_backpressure();
        test_busy();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
